// File: rtl/lif_neuron_array.sv
// lif_neuron_array: time-multiplexed array of leaky integrate-and-fire neurons.
// Weights are accumulated per neuron during S_ACCUM; an in_last beat starts a
// sweep (S_UPDATE) that updates one neuron per cycle and emits indexed spikes.
// Optional build macro LIF_ADAPT_TH_EN adds a per-neuron adaptive threshold.
module lif_neuron_array #(
  parameter int N_NEURON  = 16,
  parameter int DW        = 8,
  parameter int ACCW      = 12,
  parameter int VW        = 8,
  parameter int VTH       = 8,
  parameter int LEAK      = 1,
  parameter int VMEM_INIT = -16,
  parameter int VMEM_MIN  = -32,
  parameter int REF_DUR   = 2,
  localparam int IDW      = (N_NEURON > 1) ? $clog2(N_NEURON) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IDW-1:0]  in_id,
  input  logic [DW-1:0]   in_weight,
  input  logic            in_last,
  output logic            spike_valid,
  output logic [IDW-1:0]  spike_id,
  output logic            step_done,
  input  logic [IDW-1:0]  vmem_rd_id,
  output logic [VW-1:0]   vmem_rd
);

  localparam int RCW     = (REF_DUR > 0) ? $clog2(REF_DUR + 1) : 1;
  localparam int ACC_MAX = (1 << (ACCW - 1)) - 1;
  localparam int ACC_MIN = -(1 << (ACCW - 1));
  localparam int VW_MAX  = (1 << (VW - 1)) - 1;
  localparam int VW_MIN  = -(1 << (VW - 1));
`ifdef LIF_ADAPT_TH_EN
  localparam int TH_INC  = 4;
  localparam int TH_MAX  = (1 << VW) - 1;
`endif

  typedef enum logic {S_ACCUM, S_UPDATE} state_t;

  // Clamp a wide value into [lo, hi]; every narrowing in the datapath goes through here.
  function automatic int clamp(input int x, input int lo, input int hi);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  state_t                  state_q, state_d;
  logic [IDW-1:0]          idx_q, idx_d;
  logic                    spike_valid_q, spike_valid_d;
  logic [IDW-1:0]          spike_id_q, spike_id_d;
  logic                    step_done_q, step_done_d;
  logic signed [VW-1:0]    vmem_q [N_NEURON];
  logic signed [VW-1:0]    vmem_d [N_NEURON];
  logic signed [ACCW-1:0]  acc_q [N_NEURON];
  logic signed [ACCW-1:0]  acc_d [N_NEURON];
  logic [RCW-1:0]          ref_cnt_q [N_NEURON];
  logic [RCW-1:0]          ref_cnt_d [N_NEURON];
`ifdef LIF_ADAPT_TH_EN
  logic [VW-1:0]           th_off_q [N_NEURON];
  logic [VW-1:0]           th_off_d [N_NEURON];
`endif

  logic                    in_range;
  logic signed [VW-1:0]    vmem_cur;
  logic signed [VW-1:0]    acc_v;
  logic signed [VW+1:0]    v_sum;
  logic signed [VW-1:0]    v_new;
  int                      th_eff;
  logic                    fire;

  assign in_ready    = (state_q == S_ACCUM);
  assign in_range    = (int'(in_id) < N_NEURON);
  assign spike_valid = spike_valid_q;
  assign spike_id    = spike_id_q;
  assign step_done   = step_done_q;

  // Debug read port into the membrane array.
  always_comb begin
    vmem_rd = '0;
    if (int'(vmem_rd_id) < N_NEURON) vmem_rd = vmem_q[vmem_rd_id];
  end

  // Next-state logic: accumulate weights, or sweep one neuron per cycle.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    spike_valid_d = 1'b0;
    spike_id_d    = spike_id_q;
    step_done_d   = 1'b0;
    vmem_d        = vmem_q;
    acc_d         = acc_q;
    ref_cnt_d     = ref_cnt_q;
`ifdef LIF_ADAPT_TH_EN
    th_off_d      = th_off_q;
`endif
    vmem_cur      = vmem_q[idx_q];
    acc_v         = VW'(clamp(int'(acc_q[idx_q]), VW_MIN, VW_MAX));
    v_sum         = (VW+2)'(vmem_cur) + (VW+2)'(acc_v) - (VW+2)'(LEAK);
    v_new         = VW'(clamp(int'(v_sum), VW_MIN, VW_MAX));
`ifdef LIF_ADAPT_TH_EN
    th_eff        = clamp(VTH + int'(th_off_q[idx_q]), VW_MIN, VW_MAX);
`else
    th_eff        = VTH;
`endif
    fire          = (int'(v_new) >= th_eff);

    case (state_q)
      S_ACCUM: begin
        if (in_valid) begin
          if (in_range)
            acc_d[in_id] = ACCW'(clamp(int'(acc_q[in_id]) + int'($signed(in_weight)),
                                       ACC_MIN, ACC_MAX));
          if (in_last) begin
            state_d = S_UPDATE;
            idx_d   = '0;
          end
        end
      end
      S_UPDATE: begin
        if (ref_cnt_q[idx_q] != '0) begin
          ref_cnt_d[idx_q] = ref_cnt_q[idx_q] - RCW'(1);
          vmem_d[idx_q]    = VW'(VMEM_INIT);
        end else if (fire) begin
          spike_valid_d    = 1'b1;
          spike_id_d       = idx_q;
          vmem_d[idx_q]    = VW'(VMEM_INIT);
          ref_cnt_d[idx_q] = RCW'(REF_DUR);
`ifdef LIF_ADAPT_TH_EN
          th_off_d[idx_q]  = VW'(clamp(int'(th_off_q[idx_q]) + TH_INC, 0, TH_MAX));
`endif
        end else begin
          if (int'(v_new) < VMEM_MIN) vmem_d[idx_q] = VW'(VMEM_MIN);
          else                        vmem_d[idx_q] = v_new;
`ifdef LIF_ADAPT_TH_EN
          if (th_off_q[idx_q] != '0) th_off_d[idx_q] = th_off_q[idx_q] - VW'(1);
`endif
        end
        acc_d[idx_q] = '0;
        if (idx_q == IDW'(N_NEURON - 1)) begin
          state_d     = S_ACCUM;
          step_done_d = 1'b1;
        end else begin
          idx_d = idx_q + IDW'(1);
        end
      end
      default: state_d = S_ACCUM;
    endcase
  end

  // State and neuron storage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_ACCUM;
      idx_q         <= '0;
      spike_valid_q <= 1'b0;
      spike_id_q    <= '0;
      step_done_q   <= 1'b0;
      for (int i = 0; i < N_NEURON; i++) begin
        vmem_q[i]    <= VW'(VMEM_INIT);
        acc_q[i]     <= '0;
        ref_cnt_q[i] <= '0;
`ifdef LIF_ADAPT_TH_EN
        th_off_q[i]  <= '0;
`endif
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      spike_valid_q <= spike_valid_d;
      spike_id_q    <= spike_id_d;
      step_done_q   <= step_done_d;
      for (int i = 0; i < N_NEURON; i++) begin
        vmem_q[i]    <= vmem_d[i];
        acc_q[i]     <= acc_d[i];
        ref_cnt_q[i] <= ref_cnt_d[i];
`ifdef LIF_ADAPT_TH_EN
        th_off_q[i]  <= th_off_d[i];
`endif
      end
    end
  end

endmodule

// File: doc/lif_neuron_array.md
Name: lif_neuron_array

Overview:
- Time-multiplexed array of N_NEURON leaky integrate-and-fire neurons sharing one update datapath.
- Next generation of the single-neuron body. Adds:
  - parametrised neuron count and widths
  - per-neuron accumulators
  - saturating arithmetic and a membrane floor
  - a refractory period counted in timesteps
  - an indexed spike output stream
- Sits between the synapse/weight-fetch stage, which produces indexed weights, and the spike router.

Parameters:
- N_NEURON, 16: number of neurons; IDW = $clog2(N_NEURON), minimum 1.
- DW, 8: signed weight width.
- ACCW, 12: signed per-neuron accumulator width; must be >= DW.
- VW, 8: signed membrane width, Q4.4.
- VTH, 8: firing threshold, 0.5.
- LEAK, 1: leak subtracted every timestep, 0.0625.
- VMEM_INIT, -16: reset and post-spike membrane value.
- VMEM_MIN, -32: membrane floor.
- REF_DUR, 2: refractory length in timesteps; 0 disables refractory.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- in_valid, in, 1: weight valid.
- in_ready, out, 1: block accepts weights; high only in S_ACCUM.
- in_id, in, IDW: target neuron index.
- in_weight, in, DW: signed weight.
- in_last, in, 1: the weight carrying it is the last of the current timestep.
- spike_valid, out, 1: one-cycle spike pulse.
- spike_id, out, IDW: index of the spiking neuron.
- step_done, out, 1: one-cycle pulse when the timestep sweep completes.
- vmem_rd_id, in, IDW: debug read index.
- vmem_rd, out, VW: combinational read of vmem[vmem_rd_id].

Behaviour:
- Reset (rst high at clk edge):
  - State goes to S_ACCUM.
  - Every vmem is set to VMEM_INIT; every acc and ref_cnt is set to 0.
  - spike_valid, step_done and spike_id are 0.
  - Reset mid-sweep aborts the sweep; no spike or step_done is emitted afterwards.
- Handshake:
  - A weight is accepted when in_valid && in_ready.
  - When in_id >= N_NEURON, the weight is dropped; in_last on that beat is still honoured.
  - An accepted weight does acc[in_id] = sat_ACCW(acc[in_id] + sext(in_weight)).
  - A beat with in_last and in_valid is accumulated, then the state moves to S_UPDATE on the next edge.
  - in_ready is 0 outside S_ACCUM. in_valid while in_ready is low is ignored; no stall or error.
- State S_ACCUM: accept weights as above. Leave to S_UPDATE with idx=0 on an accepted in_last.
- State S_UPDATE: one neuron per cycle, idx = 0 .. N_NEURON-1. For neuron i:
  - If ref_cnt[i] != 0: ref_cnt[i]--; vmem[i] holds VMEM_INIT; acc is discarded; no spike.
  - Otherwise compute v = sat_VW(vmem[i] + sat_VW(acc[i]) - LEAK) in VW+2-bit signed intermediate.
    - If v >= VTH: spike; vmem[i] <= VMEM_INIT; ref_cnt[i] <= REF_DUR.
    - If v < VTH: vmem[i] <= max(v, VMEM_MIN).
  - acc[i] is cleared to 0 in every case.
  - After idx = N_NEURON-1, return to S_ACCUM.
- Spike output:
  - spike_valid and spike_id are registered: neuron i's spike appears 1 cycle after it is processed.
  - There is no backpressure; at most one spike per cycle, in ascending id order.
- Timing, with the last weight accepted in cycle t:
  - Neuron i is processed in cycle t+1+i; its spike shows in cycle t+2+i.
  - step_done pulses in cycle t+1+N_NEURON.
  - in_ready rises in cycle t+1+N_NEURON, so the next timestep's weights can be accepted that cycle.
- Timestep with no weights: the upstream block sends a beat with in_last and an out-of-range id, or with weight 0. The full sweep still runs, so leak is applied to all neurons.
- Saturation clamps to the signed min/max of the target width. There is no wrap-around anywhere.

Optional Feature:
- Macro: LIF_ADAPT_TH_EN.
- When defined:
  - Each neuron has a threshold offset th_off[i], VW bits unsigned, reset to 0.
  - The effective threshold is VTH + th_off[i], saturating.
  - On a spike, th_off[i] += TH_INC (localparam 4), saturating.
  - Each non-spiking, non-refractory update decrements th_off[i] by 1 when nonzero.
- When not defined: the threshold is the constant VTH and no th_off storage exists.

Test Plan (N_NEURON=4, defaults unless stated):
- Basic fire: reset; send neuron0 weights 10, 10, then 5 with in_last (last accepted at t) -> spike_valid=1, spike_id=0 at t+2; vmem[0]=-16; step_done at t+5.
- Refractory: after the basic fire test, send 3 timesteps each with weight 40 to neuron0. Steps 1–2: no spike, vmem[0]=-16. Step 3: v = -16+40-1 = 23 -> spike id 0.
- Leak and floor: 20 empty timesteps, each a single in_last beat with in_id=0, in_weight=0 -> vmem[1] goes -17, -18, …, clamps at -32 and stays there; no spikes.
- Accumulator and membrane saturation: 20 weights of 127 to neuron2 in one step -> acc saturates at 2047, is clamped to VW max 127; v = -16+127-1 = 110 -> spike id 2. Multiple spikes in one step (neurons 1 and 3) appear in consecutive cycles in id order.
- Handshake and reset: drive in_valid during S_UPDATE -> ignored, in_ready=0. Assert rst at sweep cycle idx=1 -> no further spike_valid or step_done; all vmem=-16; in_ready=1 next cycle.
- With LIF_ADAPT_TH_EN: neuron0 fires twice -> effective threshold goes 12, then 16; a step giving v=13 does not fire.
